// File: rtl/xcore_ifu_prefetch.sv
// xcore_ifu_prefetch: instruction prefetch queue between the instruction-memory
// port and the IF/ID register. Issues sequential fetch addresses under a credit
// limit, tracks in-order outstanding requests, buffers returned instructions
// with their PC, and discards in-flight responses after a redirect.
module xcore_ifu_prefetch #(
  parameter int              DW     = 32,
  parameter int              AW     = 32,
  parameter int              DEPTH  = 4,
  parameter logic [AW-1:0]   RST_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  // instruction-memory request/response port
  output logic          ifu_req_valid,
  output logic [AW-1:0] ifu_req_addr,
  input  logic          ifu_req_ready,
  input  logic          ifu_rsp_valid,
  input  logic [DW-1:0] ifu_rsp_data,
  // redirect
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  // decode-side head of queue
  output logic          ir_valid,
  output logic [DW-1:0] ir_data,
  output logic [AW-1:0] ir_pc,
  input  logic          ir_ready
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [AW-1:0] STEP    = AW'(4);

  // Architectural state
  logic [AW-1:0] pc_next;
  logic [AW-1:0] rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Queue storage, one {pc, data} pair per entry
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  // Next-state values
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] drop_nxt;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;

  // Per-cycle events
  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          rsp_take;
  logic          rsp_discard;
  logic          push;
  logic          pop;

  // Requests in flight plus entries held may never exceed the queue size, so
  // every response is guaranteed a slot when it arrives.
  assign credit_used   = {1'b0, count} + {1'b0, outstanding};
  assign ifu_req_valid = !reset && !flush && (credit_used < DEPTH_W);
  assign ifu_req_addr  = pc_next;
  assign req_fire      = ifu_req_valid && ifu_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take    = ifu_rsp_valid && (outstanding != '0);
  assign rsp_discard = rsp_take && (drop != '0);
  assign push        = rsp_take && (drop == '0) && !flush;
  assign pop         = ir_valid && ir_ready && !flush;

  // Head of queue; data and PC read as zero while empty.
  assign ir_valid = (count != '0);
  assign ir_data  = ir_valid ? data_mem[rd_ptr] : '0;
  assign ir_pc    = ir_valid ? pc_mem[rd_ptr]   : '0;

  // Outstanding-request and drop counter next-state.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    outstanding_nxt = outstanding;
    drop_nxt        = drop;
    unique case ({req_fire, rsp_take})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: outstanding_nxt = outstanding;
    endcase
    if (flush) begin
      // Everything still in flight belongs to the old stream. The response
      // arriving this cycle is already consumed, so it is not counted again.
      drop_nxt = outstanding - CW'(rsp_take);
    end else if (rsp_discard) begin
      drop_nxt = drop - CW'(1);
    end
  end

  // Queue occupancy and pointer next-state; a flush empties the queue outright.
  always_comb begin
    count_nxt  = count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Fetch address: restart on redirect, otherwise step one word per accepted request.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) begin
      pc_next <= RST_PC;
    end else if (flush) begin
      pc_next <= flush_pc;
    end else if (req_fire) begin
      pc_next <= pc_next + STEP;
    end
  end

  // PC tag for the next kept response; advances only on entries actually queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_pc <= RST_PC;
    end else if (flush) begin
      rsp_pc <= flush_pc;
    end else if (push) begin
      rsp_pc <= rsp_pc + STEP;
    end
  end

  // Counter and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      count       <= count_nxt;
      outstanding <= outstanding_nxt;
      drop        <= drop_nxt;
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
    end
  end

  // Queue storage write on push.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read while count says they
    // are valid, and the outputs are forced to zero when the queue is empty.
    if (push) begin
      data_mem[wr_ptr] <= ifu_rsp_data;
      pc_mem[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_xcore_ifu_prefetch.sv
// Testbench for xcore_ifu_prefetch: an in-order memory model with per-request
// latency feeds the DUT; kept responses are pushed to a scoreboard queue and
// popped when decode consumes the head.
module tb_xcore_ifu_prefetch;

  localparam int            DW     = 32;
  localparam int            AW     = 32;
  localparam int            DEPTH  = 4;
  localparam logic [AW-1:0] RST_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ifu_req_valid;
  logic [AW-1:0] ifu_req_addr;
  logic          ifu_req_ready = 1'b0;
  logic          ifu_rsp_valid = 1'b0;
  logic [DW-1:0] ifu_rsp_data = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_pc = '0;
  logic          ir_valid;
  logic [DW-1:0] ir_data;
  logic [AW-1:0] ir_pc;
  logic          ir_ready = 1'b0;

  always #5 clk = ~clk;

  xcore_ifu_prefetch #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .RST_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_addr  (ifu_req_addr),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .ir_valid      (ir_valid),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc),
    .ir_ready      (ir_ready)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int unsigned   epoch;
    int unsigned   due;
  } req_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  req_t          pend_q[$];   // requests accepted by the memory model
  exp_t          exp_q[$];    // scoreboard: instructions decode should see
  logic [AW-1:0] pc_model;
  int unsigned   epoch = 0;
  int unsigned   cyc = 0;

  int vectors = 0;
  int miscompares = 0;

  // Per-cycle stimulus knobs
  logic          d_flush = 1'b0;
  logic [AW-1:0] d_flush_pc = '0;
  logic          d_ir_ready = 1'b0;
  logic          d_mem_ready = 1'b0;
  logic          d_spurious = 1'b0;
  int unsigned   lat = 1;

  // Observed DUT activity
  logic [AW-1:0] fire_log[$];
  logic [AW-1:0] pop_log[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [AW-1:0] log_at(input logic [AW-1:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 'x;
  endfunction

  task automatic clear_logs();
    fire_log.delete();
    pop_log.delete();
  endtask

  task automatic model_reset();
    pend_q.delete();
    exp_q.delete();
    epoch++;
    pc_model = RST_PC;
    clear_logs();
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic cycle();
    req_t        front;
    exp_t        head;
    logic        exp_req;
    logic        exp_ir;
    logic        rsp_now;
    int unsigned due;
    flush         = d_flush;
    flush_pc      = d_flush_pc;
    ir_ready      = d_ir_ready;
    ifu_req_ready = d_mem_ready;
    rsp_now = (pend_q.size() != 0) && (pend_q[0].due <= cyc);
    if (rsp_now) begin
      front         = pend_q[0];
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data  = mem_word(front.addr);
    end else if (d_spurious && pend_q.size() == 0) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_data  = 32'hDEAD_BEEF;
    end else begin
      ifu_rsp_valid = 1'b0;
      ifu_rsp_data  = '0;
    end
    #1;
    exp_req = !d_flush && (exp_q.size() + pend_q.size() < DEPTH);
    vectors++;
    if (ifu_req_valid !== exp_req) begin
      miscompares++;
      $display("FAIL req_valid cyc=%0d: got %b want %b", cyc, ifu_req_valid, exp_req);
    end
    if (exp_req) begin
      vectors++;
      if (ifu_req_addr !== pc_model) begin
        miscompares++;
        $display("FAIL req_addr cyc=%0d: got %h want %h", cyc, ifu_req_addr, pc_model);
      end
    end
    exp_ir = (exp_q.size() != 0);
    vectors++;
    if (ir_valid !== exp_ir) begin
      miscompares++;
      $display("FAIL ir_valid cyc=%0d: got %b want %b", cyc, ir_valid, exp_ir);
    end
    if (exp_ir) begin
      head = exp_q[0];
      vectors++;
      if (ir_pc !== head.pc || ir_data !== head.data) begin
        miscompares++;
        $display("FAIL ir_head cyc=%0d: got pc=%h data=%h want pc=%h data=%h",
                 cyc, ir_pc, ir_data, head.pc, head.data);
      end
    end
    if (ifu_req_valid === 1'b1 && d_mem_ready) fire_log.push_back(ifu_req_addr);
    if (ir_valid === 1'b1 && d_ir_ready && !d_flush) pop_log.push_back(ir_pc);
    // Reference-model state update for the coming edge
    if (exp_ir && d_ir_ready && !d_flush) void'(exp_q.pop_front());
    if (rsp_now) begin
      void'(pend_q.pop_front());
      if (!d_flush && front.epoch == epoch)
        exp_q.push_back('{front.addr, mem_word(front.addr)});
    end
    if (d_flush) begin
      exp_q.delete();
      epoch++;
      pc_model = d_flush_pc;
    end else if (exp_req && d_mem_ready) begin
      due = cyc + lat;
      if (pend_q.size() != 0 && pend_q[$].due >= due) due = pend_q[$].due + 1;
      pend_q.push_back('{pc_model, epoch, due});
      pc_model = pc_model + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    flush         = 1'b0;
    ir_ready      = 1'b0;
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_rsp_data  = '0;
    d_flush       = 1'b0;
    d_spurious    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (ifu_req_valid !== 1'b0 || ir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valids: got req=%b ir=%b want 0 0", ifu_req_valid, ir_valid);
    end
    vectors++;
    if (ir_data !== '0 || ir_pc !== '0) begin
      miscompares++;
      $display("FAIL reset_head: got data=%h pc=%h want 0 0", ir_data, ir_pc);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    d_ir_ready = 1'b1; d_mem_ready = 1'b1; lat = 1;
    repeat (20) cycle();
    vectors++;
    if (fire_log.size() != 20 || log_at(fire_log, 1) !== 32'h4) begin
      miscompares++;
      $display("FAIL stream_fires: got n=%0d a1=%h want n=20 a1=00000004",
               fire_log.size(), log_at(fire_log, 1));
    end
    vectors++;
    if (pop_log.size() != 18 || log_at(pop_log, 17) !== 32'h44) begin
      miscompares++;
      $display("FAIL stream_pops: got n=%0d last=%h want n=18 last=00000044",
               pop_log.size(), log_at(pop_log, 17));
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    d_ir_ready = 1'b0; d_mem_ready = 1'b1; lat = 1;
    repeat (10) cycle();
    vectors++;
    if (fire_log.size() != DEPTH || log_at(fire_log, 3) !== 32'hC) begin
      miscompares++;
      $display("FAIL bp_fill: got n=%0d a3=%h want n=4 a3=0000000c",
               fire_log.size(), log_at(fire_log, 3));
    end
    clear_logs();
    d_ir_ready = 1'b1;
    repeat (10) cycle();
    vectors++;
    if (log_at(pop_log, 0) !== 32'h0 || log_at(pop_log, 3) !== 32'hC) begin
      miscompares++;
      $display("FAIL bp_drain: got p0=%h p3=%h want 00000000 0000000c",
               log_at(pop_log, 0), log_at(pop_log, 3));
    end
    vectors++;
    if (log_at(fire_log, 0) !== 32'h10) begin
      miscompares++;
      $display("FAIL bp_resume: got %h want 00000010", log_at(fire_log, 0));
    end
  endtask

  task automatic test_flush_late();
    do_reset();
    d_ir_ready = 1'b1; d_mem_ready = 1'b1; lat = 3;
    repeat (2) cycle();
    d_flush = 1'b1; d_flush_pc = 32'h100;
    cycle();
    d_flush = 1'b0;
    clear_logs();
    repeat (12) cycle();
    vectors++;
    if (log_at(fire_log, 0) !== 32'h100) begin
      miscompares++;
      $display("FAIL late_req: got %h want 00000100", log_at(fire_log, 0));
    end
    vectors++;
    if (log_at(pop_log, 0) !== 32'h100) begin
      miscompares++;
      $display("FAIL late_first_pc: got %h want 00000100", log_at(pop_log, 0));
    end
  endtask

  task automatic test_flush_full();
    bit found = 1'b0;
    do_reset();
    d_ir_ready = 1'b0; d_mem_ready = 1'b1; lat = 3;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_q.size() >= 2 && pend_q.size() >= 2 && pend_q[0].due <= cyc) found = 1'b1;
      else cycle();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL full_setup: got no full-credit cycle want one within 20");
    end
    d_ir_ready = 1'b1; d_flush = 1'b1; d_flush_pc = 32'h200;
    cycle();
    d_flush = 1'b0;
    vectors++;
    if (ir_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_empty: got ir_valid=%b want 0", ir_valid);
    end
    clear_logs();
    repeat (12) cycle();
    vectors++;
    if (log_at(pop_log, 0) !== 32'h200 || log_at(fire_log, 0) !== 32'h200) begin
      miscompares++;
      $display("FAIL full_restart: got pop=%h req=%h want 00000200 00000200",
               log_at(pop_log, 0), log_at(fire_log, 0));
    end
  endtask

  task automatic test_wrap();
    d_ir_ready = 1'b1; d_mem_ready = 1'b1; lat = 1;
    d_flush = 1'b1; d_flush_pc = 32'hFFFF_FFFC;
    cycle();
    d_flush = 1'b0;
    clear_logs();
    repeat (8) cycle();
    vectors++;
    if (log_at(fire_log, 0) !== 32'hFFFF_FFFC || log_at(fire_log, 1) !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_req: got %h %h want fffffffc 00000000",
               log_at(fire_log, 0), log_at(fire_log, 1));
    end
    vectors++;
    if (log_at(pop_log, 0) !== 32'hFFFF_FFFC || log_at(pop_log, 1) !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_pc: got %h %h want fffffffc 00000000",
               log_at(pop_log, 0), log_at(pop_log, 1));
    end
  endtask

  task automatic test_protocol_error();
    do_reset();
    d_ir_ready = 1'b1; d_mem_ready = 1'b0; d_spurious = 1'b1; lat = 1;
    repeat (3) cycle();
    d_spurious = 1'b0; d_mem_ready = 1'b1;
    clear_logs();
    repeat (6) cycle();
    vectors++;
    if (log_at(pop_log, 0) !== RST_PC) begin
      miscompares++;
      $display("FAIL spurious_ignored: got %h want %h", log_at(pop_log, 0), RST_PC);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      d_ir_ready  = ($urandom_range(0, 3) != 0);
      d_mem_ready = ($urandom_range(0, 4) != 0);
      lat         = $urandom_range(1, 4);
      d_flush     = ($urandom_range(0, 24) == 0);
      d_flush_pc  = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end
    d_flush = 1'b0;
    vectors++;
    if (pop_log.size() == 0) begin
      miscompares++;
      $display("FAIL b2b_progress: got 0 pops want >0");
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    do_reset();
    d_ir_ready = 1'b0; d_mem_ready = 1'b1; lat = 1;
    for (int i = 0; i < 20 && !found; i++) begin
      if (exp_q.size() == 3) found = 1'b1;
      else cycle();
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_setup: got no 3-entry queue want one within 20");
    end
    ifu_rsp_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (ir_valid !== 1'b0 || ifu_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async: got ir=%b req=%b want 0 0", ir_valid, ifu_req_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    d_ir_ready = 1'b1;
    repeat (6) cycle();
    vectors++;
    if (log_at(fire_log, 0) !== RST_PC || log_at(pop_log, 0) !== RST_PC) begin
      miscompares++;
      $display("FAIL mid_restart: got req=%h pop=%h want %h", log_at(fire_log, 0),
               log_at(pop_log, 0), RST_PC);
    end
  endtask

  initial begin
    pc_model = RST_PC;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_late();
    test_flush_full();
    test_wrap();
    test_protocol_error();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
